rob_commit_ctrl: RTL

//  In-order retirement controller feeding the register file's single commit port.

---
 rtl/rob_commit_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rob_commit_ctrl.sv
// In-order retirement controller for a single-port register file commit path.
// Hands out rename tags 1..DEPTH at issue, absorbs out-of-order writebacks and
// retires completed entries in program order, one per cycle at most.
module rob_commit_ctrl #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int TAG_W = 3,
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [REG_W-1:0] alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [XLEN-1:0]  wb_data,
  output logic             commit,
  output logic [REG_W-1:0] reg_num,
  output logic [XLEN-1:0]  data_in,
  output logic [TAG_W-1:0] num_in,
  output logic [TAG_W-1:0] count,
  output logic             empty
);

  localparam logic [TAG_W-1:0] LAST = TAG_W'(DEPTH - 1);
  localparam logic [TAG_W-1:0] FULL = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] ONE  = TAG_W'(1);

  // Per-entry state; entry i carries tag i+1 so tag 0 can mean "no dependency".
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] done;
  logic [REG_W-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];

  logic [TAG_W-1:0] head, tail, wb_idx;
  logic             alloc_fire, wb_fire, retire_fire;

  assign alloc_ready = (count < FULL);
  assign alloc_tag   = tail + ONE;
  assign empty       = (count == '0);
  assign wb_idx      = wb_tag - ONE;

  // Alloc readiness looks only at the pre-edge count, so a full ROB refuses
  // an alloc even when the head retires on the same edge.
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  // A tag that is unallocated or already done is silently dropped; tag 0 never matches.
  assign wb_fire     = wb_valid && !flush && (wb_tag != '0) && vld[wb_idx] && !done[wb_idx];
  // Retire sees pre-edge done bits only: no writeback-to-commit bypass.
  assign retire_fire = vld[head] && done[head];

  // Valid/done bookkeeping; alloc, writeback and retire never hit the same slot
  // with conflicting updates (alloc needs !valid, wb needs !done, retire needs done).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld  <= '0;
      done <= '0;
    end else if (flush) begin
      vld  <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (retire_fire && head == TAG_W'(i)) begin
          vld[i]  <= 1'b0;
          done[i] <= 1'b0;
        end
        if (alloc_fire && tail == TAG_W'(i)) begin
          vld[i]  <= 1'b1;
          done[i] <= 1'b0;
        end
        if (wb_fire && wb_idx == TAG_W'(i)) begin
          done[i] <= 1'b1;
        end
      end
    end
  end

  // Payload storage; contents are only meaningful while the valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_fire) rd_q[tail] <= alloc_rd;
    if (wb_fire)    data_q[wb_idx] <= wb_data;
  end

  // Head/tail pointers and occupancy count; both pointers wrap DEPTH-1 -> 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (retire_fire) head <= (head == LAST) ? '0 : head + ONE;
      if (alloc_fire)  tail <= (tail == LAST) ? '0 : tail + ONE;
      if (alloc_fire && !retire_fire)      count <= count + ONE;
      else if (!alloc_fire && retire_fire) count <= count - ONE;
    end
  end

  // Registered RF write port; x0 entries retire without raising the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit  <= 1'b0;
      reg_num <= '0;
      data_in <= '0;
      num_in  <= '0;
    end else if (flush) begin
      commit  <= 1'b0;
    end else if (retire_fire) begin
      commit  <= (rd_q[head] != '0);
      reg_num <= rd_q[head];
      data_in <= data_q[head];
      num_in  <= head + ONE;
    end else begin
      commit  <= 1'b0;
    end
  end

endmodule
